acondicionador_botones: RTL

- Input-conditioning stage directly upstream of the pet behaviour FSM.
- Takes raw, bouncy, asynchronous board pushbuttons and the tilt switch and synchronises and debounces them.
- Delivers clean single-cycle command pulses (botonSleep, botonAwake, botonFeed, botonPlay) and a debounced level (giro) in the FSM's clock domain.
- Also converts a long press of a dedicated button into a reset request, and a short press of it into a test-mode toggle.

---
 rtl/acondicionador_botones_pkg.sv | 23 ++
 rtl/acondicionador_botones_debounce_canal.sv | 114 +++++++++++
 rtl/acondicionador_botones.sv | 114 +++++++++++
 3 files changed

// File: rtl/acondicionador_botones_pkg.sv
// Shared definitions for the pushbutton / tilt-switch conditioning stage.
package acondicionador_botones_pkg;

  localparam int unsigned N_BTN    = 5;
  localparam int unsigned CH_SLEEP = 0;
  localparam int unsigned CH_AWAKE = 1;
  localparam int unsigned CH_FEED  = 2;
  localparam int unsigned CH_PLAY  = 3;
  localparam int unsigned CH_RST   = 4;

  // Debounce states: stable released, candidate press, stable pressed, candidate release.
  typedef enum logic [1:0] {
    REL    = 2'd0,
    PEND_P = 2'd1,
    PRES   = 2'd2,
    PEND_R = 2'd3
  } deb_state_t;

  function automatic logic deb_level(input deb_state_t s);
    return (s == PRES) || (s == PEND_R);
  endfunction

endpackage

// File: rtl/acondicionador_botones_debounce_canal.sv
// One input channel: 2-flop synchroniser, tick-based debounce FSM,
// registered debounced level and a one-clock rise pulse.
module debounce_canal
  import acondicionador_botones_pkg::*;
#(
  parameter int unsigned DEB_MS = 20,
  parameter bit          INVERT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEB_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MS - 1);

  logic          s1;
  logic          s2;
  logic          pressed;
  deb_state_t    state;
  deb_state_t    state_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          level_d;

  // Synchroniser resets to the released raw value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= INVERT;
      s2 <= INVERT;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign pressed = s2 ^ INVERT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REL;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // A candidate level must survive DEB_MS ticks; any reversal abandons it.
  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      REL: begin
        if (pressed) begin
          state_nx = PEND_P;
          count_nx = '0;
        end
      end
      PEND_P: begin
        if (!pressed) begin
          state_nx = REL;
          count_nx = '0;
        end else if (tick) begin
          if (count == CNT_LAST) begin
            state_nx = PRES;
            count_nx = '0;
          end else begin
            count_nx = count + CW'(1);
          end
        end
      end
      PRES: begin
        if (!pressed) begin
          state_nx = PEND_R;
          count_nx = '0;
        end
      end
      PEND_R: begin
        if (pressed) begin
          state_nx = PRES;
          count_nx = '0;
        end else if (tick) begin
          if (count == CNT_LAST) begin
            state_nx = REL;
            count_nx = '0;
          end else begin
            count_nx = count + CW'(1);
          end
        end
      end
      default: begin
        state_nx = REL;
        count_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level   <= deb_level(state);
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/acondicionador_botones.sv
// Conditions raw pushbuttons and tilt switch into clean pulses/levels for the
// pet FSM; button 4 gives a long-press reset request or a short-press test toggle.
module acondicionador_botones
  import acondicionador_botones_pkg::*;
#(
  parameter int unsigned COUNT_MAX  = 50000,
  parameter int unsigned DEB_MS     = 20,
  parameter int unsigned LONG_MS    = 3000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             giro_raw,
  output logic             botonSleep,
  output logic             botonAwake,
  output logic             botonFeed,
  output logic             botonPlay,
  output logic             giro,
  output logic             rst_req,
  output logic             test_mode
);

  localparam int unsigned DW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam int unsigned HW = $clog2(LONG_MS + 1);

  logic [DW-1:0]    div;
  logic             tick;
  logic [N_BTN-1:0] lvl;
  logic [N_BTN-1:0] rise;
  logic             giro_rise;
  logic             unused_bits;
  logic [HW-1:0]    hold_cnt;
  logic             long_flag;
  logic             rst_lvl_d;

  // Millisecond tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      tick <= 1'b0;
    end else if (div == DW'(COUNT_MAX - 1)) begin
      div  <= '0;
      tick <= 1'b1;
    end else begin
      div  <= div + DW'(1);
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
    debounce_canal #(
      .DEB_MS (DEB_MS),
      .INVERT (ACTIVE_LOW)
    ) u_canal (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .tick  (tick),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  debounce_canal #(
    .DEB_MS (DEB_MS),
    .INVERT (1'b0)
  ) u_giro (
    .clk   (clk),
    .rst   (rst),
    .raw   (giro_raw),
    .tick  (tick),
    .level (giro),
    .rise  (giro_rise)
  );

  assign botonSleep = rise[CH_SLEEP];
  assign botonAwake = rise[CH_AWAKE];
  assign botonFeed  = rise[CH_FEED];
  assign botonPlay  = rise[CH_PLAY];

  // Levels of the command buttons and the pulses of channel 4 / tilt are not needed.
  assign unused_bits = ^{lvl[CH_PLAY:CH_SLEEP], rise[CH_RST], giro_rise};

  // Long-press detection and test-mode toggle on the debounced channel 4 level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      long_flag <= 1'b0;
      rst_req   <= 1'b0;
      test_mode <= 1'b0;
      rst_lvl_d <= 1'b0;
    end else begin
      rst_req   <= 1'b0;
      rst_lvl_d <= lvl[CH_RST];
      if (lvl[CH_RST]) begin
        if (tick && (hold_cnt != HW'(LONG_MS))) begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_cnt == HW'(LONG_MS - 1)) begin
            rst_req   <= 1'b1;
            long_flag <= 1'b1;
          end
        end
      end else if (rst_lvl_d) begin
        if (!long_flag) begin
          test_mode <= ~test_mode;
        end
        hold_cnt  <= '0;
        long_flag <= 1'b0;
      end
    end
  end

endmodule
